// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-add multiplier, one multiplier bit per clock, start/busy/done handshake.
// Optional MULT_SIGNED_EN: two's-complement operands with an extra NEG fix-up cycle.
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo
);

   localparam int CW = $clog2(WIDTH);

`ifdef MULT_SIGNED_EN
   typedef enum logic [1:0] {IDLE, BUSY, DONE, NEG} state_t;
`else
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`endif

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] m;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] a_ld, b_ld;
   logic             accept;
   logic             last_iter;
`ifdef MULT_SIGNED_EN
   logic             neg;
`endif

   assign accept    = start && (state == IDLE || state == DONE);
   assign last_iter = (cnt == CW'(WIDTH - 1));

   // Operands enter the shift-add core as unsigned magnitudes in the signed build.
   always_comb begin
`ifdef MULT_SIGNED_EN
      a_ld = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
      b_ld = multiplier[WIDTH-1]   ? -multiplier   : multiplier;
`else
      a_ld = multiplicand;
      b_ld = multiplier;
`endif
   end

   // Carry out of the partial-product add lands in sum[WIDTH] and shifts into product_hi.
   always_comb begin
      sum = {1'b0, product_hi} + (product_lo[0] ? {1'b0, m} : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = BUSY;
         DONE:    if (start) state_nxt = BUSY;
`ifdef MULT_SIGNED_EN
         BUSY:    if (last_iter) state_nxt = NEG;
         NEG:     state_nxt = DONE;
`else
         BUSY:    if (last_iter) state_nxt = DONE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MULT_SIGNED_EN
   assign busy = (state == BUSY) || (state == NEG);
`else
   assign busy = (state == BUSY);
`endif
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m          <= '0;
         cnt        <= '0;
         product_hi <= '0;
         product_lo <= '0;
`ifdef MULT_SIGNED_EN
         neg        <= 1'b0;
`endif
      end else if (accept) begin
         m          <= a_ld;
         cnt        <= '0;
         product_hi <= '0;
         product_lo <= b_ld;
`ifdef MULT_SIGNED_EN
         neg        <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
`endif
      end else if (state == BUSY) begin
         product_hi <= sum[WIDTH:1];
         product_lo <= {sum[0], product_lo[WIDTH-1:1]};
         cnt        <= cnt + CW'(1);
`ifdef MULT_SIGNED_EN
      end else if (state == NEG) begin
         if (neg) {product_hi, product_lo} <= -{product_hi, product_lo};
`endif
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier (either MULT_SIGNED_EN build).
module tb_seq_multiplier;

   localparam int WIDTH = 32;
`ifdef MULT_SIGNED_EN
   localparam int LAT = WIDTH + 1;
`else
   localparam int LAT = WIDTH;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] multiplicand = '0;
   logic [WIDTH-1:0] multiplier = '0;
   logic             busy, done;
   logic [WIDTH-1:0] product_hi, product_lo;

   int n_tests = 0;
   int n_fail  = 0;

   seq_multiplier #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product_hi   (product_hi),
      .product_lo   (product_lo)
   );

   always #5 clk = ~clk;

   // Caller is at a negedge. Returns cycles from accepting edge until done, and whether busy held throughout.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int pulse_at,
                         output int lat, output logic busy_ok);
      start = 1'b1; multiplicand = a; multiplier = b;
      @(posedge clk); @(negedge clk);
      start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
      lat = 0; busy_ok = 1'b1;
      while (!done && lat < 200) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (lat == pulse_at) begin
            start = 1'b1; multiplicand = 32'd100; multiplier = 32'd100;
         end
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         lat++;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({busy, done} !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
      end
      n_tests++;
      if ({product_hi, product_lo} !== 64'd0) begin
         n_fail++; $display("FAIL reset_product: got %h_%h required 0", product_hi, product_lo);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int lat; logic bok;
      run_op(32'd3, 32'd5, -1, lat, bok);
      n_tests++;
      if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, LAT); end
      n_tests++;
      if (bok !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy_window: busy_ok=%b busy_at_done=%b required 1/0", bok, busy);
      end
      n_tests++;
      if ({product_hi, product_lo} !== 64'h0000_0000_0000_000F) begin
         n_fail++; $display("FAIL basic_product: got %h_%h required 00000000_0000000f", product_hi, product_lo);
      end
      repeat (3) @(negedge clk);
      n_tests++;
      if (done !== 1'b1 || busy !== 1'b0 || {product_hi, product_lo} !== 64'h0000_0000_0000_000F) begin
         n_fail++; $display("FAIL basic_hold: done=%b busy=%b product=%h_%h", done, busy, product_hi, product_lo);
      end
   endtask

   task automatic test_max;
      int lat; logic bok;
      logic [63:0] exp;
`ifdef MULT_SIGNED_EN
      exp = 64'h0000_0000_0000_0001;
`else
      exp = 64'hFFFF_FFFE_0000_0001;
`endif
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, bok);
      n_tests++;
      if (lat !== LAT || {product_hi, product_lo} !== exp) begin
         n_fail++; $display("FAIL max_operands: lat=%0d product=%h_%h required lat=%0d product=%h", lat, product_hi, product_lo, LAT, exp);
      end
   endtask

   task automatic test_start_while_busy;
      int lat; logic bok;
      run_op(32'd7, 32'd9, 10, lat, bok);
      n_tests++;
      if (lat !== LAT || bok !== 1'b1) begin
         n_fail++; $display("FAIL busy_start_latency: lat=%0d busy_ok=%b required %0d/1", lat, bok, LAT);
      end
      n_tests++;
      if ({product_hi, product_lo} !== 64'd63) begin
         n_fail++; $display("FAIL busy_start_product: got %h_%h required 0_0000003f", product_hi, product_lo);
      end
      run_op(32'd100, 32'd100, -1, lat, bok);
      n_tests++;
      if (lat !== LAT || {product_hi, product_lo} !== 64'h2710) begin
         n_fail++; $display("FAIL start_from_done: lat=%0d product=%h_%h required lat=%0d product=0_00002710", lat, product_hi, product_lo, LAT);
      end
   endtask

   task automatic test_reset_mid;
      int lat; logic bok;
      start = 1'b1; multiplicand = 32'h1234_5678; multiplier = 32'h9ABC_DEF0;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy, done} !== 2'b00 || {product_hi, product_lo} !== 64'd0) begin
         n_fail++; $display("FAIL reset_async: busy=%b done=%b product=%h_%h required all 0", busy, done, product_hi, product_lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy, done} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle_after: busy/done=%b required 00", {busy, done});
      end
      run_op(32'd2, 32'd2, -1, lat, bok);
      n_tests++;
      if (lat !== LAT || {product_hi, product_lo} !== 64'd4) begin
         n_fail++; $display("FAIL reset_recover: lat=%0d product=%h_%h required lat=%0d product=4", lat, product_hi, product_lo, LAT);
      end
   endtask

   task automatic test_zero_back_to_back;
      int lat; logic bok;
      logic [63:0] exp;
`ifdef MULT_SIGNED_EN
      exp = 64'hFFFF_FFFF_DEAD_BEEF;
`else
      exp = 64'h0000_0000_DEAD_BEEF;
`endif
      run_op(32'd0, 32'hDEAD_BEEF, -1, lat, bok);
      n_tests++;
      if (lat !== LAT || {product_hi, product_lo} !== 64'd0) begin
         n_fail++; $display("FAIL zero_operand: lat=%0d product=%h_%h required lat=%0d product=0", lat, product_hi, product_lo, LAT);
      end
      run_op(32'd1, 32'hDEAD_BEEF, -1, lat, bok);
      n_tests++;
      if (lat !== LAT || bok !== 1'b1 || {product_hi, product_lo} !== exp) begin
         n_fail++; $display("FAIL back_to_back: lat=%0d busy_ok=%b product=%h_%h required lat=%0d product=%h", lat, bok, product_hi, product_lo, LAT, exp);
      end
   endtask

   task automatic test_sign;
      int lat; logic bok;
      logic [63:0] exp1, exp2;
`ifdef MULT_SIGNED_EN
      exp1 = 64'hFFFF_FFFF_FFFF_FFFA;
      exp2 = 64'hFFFF_FFFF_0000_0000;
`else
      exp1 = 64'h0000_0002_FFFF_FFFA;
      exp2 = 64'h0000_0001_0000_0000;
`endif
      run_op(32'hFFFF_FFFE, 32'd3, -1, lat, bok);
      n_tests++;
      if (lat !== LAT || {product_hi, product_lo} !== exp1) begin
         n_fail++; $display("FAIL sign_neg_small: lat=%0d product=%h_%h required lat=%0d product=%h", lat, product_hi, product_lo, LAT, exp1);
      end
      run_op(32'h8000_0000, 32'd2, -1, lat, bok);
      n_tests++;
      if (lat !== LAT || {product_hi, product_lo} !== exp2) begin
         n_fail++; $display("FAIL sign_most_negative: lat=%0d product=%h_%h required lat=%0d product=%h", lat, product_hi, product_lo, LAT, exp2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_start_while_busy();
      test_reset_mid();
      test_zero_back_to_back();
      test_sign();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
